seq_divider_nxn: RTL and testbench

- Unsigned radix-2 restoring divider. It is the inverse companion of the datapath multipliers and computes quotient and remainder of two WIDTH-bit operands.
- Iterative: one quotient bit is resolved per clock, MSB first, behind a start/done handshake.
- Sits beside the multiplier blocks as the divide resource for small arithmetic datapaths.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 28 ++
 rtl/seq_divider_nxn.sv | 121 ++++++++++++
 tb/tb_seq_divider_nxn.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and sizing helpers for the sequential divider
package div_pkg;

  // Two-bit state code; the unused codes fall back to idle behaviour.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01
  } div_state_e;

  // Width of the iteration counter needed to count up to WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step: shift in a dividend bit, trial-subtract
import div_pkg::*;

module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   p_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   p_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] p_shift;
  logic [WIDTH:0] d_ext;
  logic [WIDTH:0] p_diff;

  assign p_shift = {p_i[WIDTH-1:0], bit_i};
  assign d_ext   = {1'b0, d_i};
  assign p_diff  = p_shift - d_ext;

  // Keep the difference only when the shifted remainder covers the divisor.
  always_comb begin
    q_bit_o = (p_shift >= d_ext);
    p_o     = q_bit_o ? p_diff : p_shift;
  end

endmodule

// File: rtl/seq_divider_nxn.sv
// rtl/seq_divider_nxn.sv - iterative unsigned restoring divider, one quotient bit per clock
import div_pkg::*;

module seq_divider_nxn #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   step_p;
  logic             step_bit;
  logic [WIDTH-1:0] q_shift;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_i     (p_q),
    .bit_i   (q_q[WIDTH-1]),
    .d_i     (d_q),
    .p_o     (step_p),
    .q_bit_o (step_bit)
  );

  assign q_shift = {q_q[WIDTH-2:0], step_bit};

  // State and datapath registers; reset clears everything and aborts any run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: accept in idle, iterate in run, publish results on the last step.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        p_d   = step_p;
        q_d   = q_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          quo_d   = q_shift;
          rem_d   = step_p[WIDTH-1:0];
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (start) begin
          if (divisor == '0) begin
            // Divide by zero resolves immediately without entering run.
            quo_d  = '1;
            rem_d  = dividend;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            d_d     = divisor;
            q_d     = dividend;
            p_d     = '0;
            cnt_d   = '0;
            state_d = ST_RUN;
          end
        end
      end
    endcase
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign busy        = (state_q == ST_RUN);
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_nxn.sv
// tb/tb_seq_divider_nxn.sv - self-checking bench for seq_divider_nxn at WIDTH 4 and 8
module tb_seq_divider_nxn;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, q4, r4;
  logic       busy4, done4, dz4;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, q8, r8;
  logic       busy8, done8, dz8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_divider_nxn #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .dividend(a4), .divisor(b4),
    .quotient(q4), .remainder(r4), .busy(busy4), .done(done4), .div_by_zero(dz4)
  );

  seq_divider_nxn #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .dividend(a8), .divisor(b8),
    .quotient(q8), .remainder(r8), .busy(busy8), .done(done8), .div_by_zero(dz8)
  );

  typedef struct {
    int a;
    int b;
    int eq;
    int er;
    int edz;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input int w, input bit s, input int a, input int b);
    if (w == 4) begin
      start4 = s; a4 = a[3:0]; b4 = b[3:0];
    end else begin
      start8 = s; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  function automatic int get_q(input int w);
    return (w == 4) ? int'(q4) : int'(q8);
  endfunction
  function automatic int get_r(input int w);
    return (w == 4) ? int'(r4) : int'(r8);
  endfunction
  function automatic int get_dz(input int w);
    return (w == 4) ? int'(dz4) : int'(dz8);
  endfunction
  function automatic int get_busy(input int w);
    return (w == 4) ? int'(busy4) : int'(busy8);
  endfunction
  function automatic int get_done(input int w);
    return (w == 4) ? int'(done4) : int'(done8);
  endfunction

  // Waits for done at negedges, counting rising edges since the accepting edge.
  task automatic wait_done(input int w, input int n0, output int lat);
    lat = n0;
    while (get_done(w) == 0 && lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  // One complete operation against plain-arithmetic expectations.
  task automatic run_op(input string tag, input int w, input int a, input int b);
    int mask, eq, er, edz, elat, lat, busy_first;
    mask = (1 << w) - 1;
    if (b == 0) begin
      eq = mask; er = a; edz = 1; elat = 0;
    end else begin
      eq = a / b; er = a % b; edz = 0; elat = w;
    end
    set_in(w, 1'b1, a, b);
    @(posedge clk);
    @(negedge clk);
    set_in(w, 1'b0, 0, 0);
    busy_first = get_busy(w);
    wait_done(w, 0, lat);
    chk({tag, " latency"}, lat, elat);
    chk({tag, " busy"}, busy_first, (b == 0) ? 0 : 1);
    chk({tag, " quotient"}, get_q(w), eq);
    chk({tag, " remainder"}, get_r(w), er);
    chk({tag, " div_by_zero"}, get_dz(w), edz);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " done pulse"}, get_done(w), 0);
    chk({tag, " hold quotient"}, get_q(w), eq);
  endtask

  vec_t vecs[$];
  int lat;

  initial begin
    vecs.push_back('{13, 3, 4, 1, 0});
    vecs.push_back('{7, 0, 15, 7, 1});
    vecs.push_back('{15, 15, 1, 0, 0});
    vecs.push_back('{0, 5, 0, 0, 0});
    vecs.push_back('{15, 1, 15, 0, 0});
    vecs.push_back('{3, 9, 0, 3, 0});
    vecs.push_back('{8, 8, 1, 0, 0});
    vecs.push_back('{0, 0, 15, 0, 1});

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset quotient", int'(q4), 0);
    chk("reset remainder", int'(r4), 0);
    chk("reset busy", int'(busy4), 0);
    chk("reset done", int'(done4), 0);
    chk("reset div_by_zero", int'(dz4), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table with hand-computed results
    for (int i = 0; i < vecs.size(); i++) begin
      set_in(4, 1'b1, vecs[i].a, vecs[i].b);
      @(posedge clk);
      @(negedge clk);
      set_in(4, 1'b0, 0, 0);
      wait_done(4, 0, lat);
      chk($sformatf("vec%0d latency", i), lat, (vecs[i].b == 0) ? 0 : 4);
      chk($sformatf("vec%0d quotient", i), int'(q4), vecs[i].eq);
      chk($sformatf("vec%0d remainder", i), int'(r4), vecs[i].er);
      chk($sformatf("vec%0d div_by_zero", i), int'(dz4), vecs[i].edz);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d done pulse", i), int'(done4), 0);
    end

    // Back-to-back: 9/2 then 14/3 started in the done cycle
    set_in(4, 1'b1, 9, 2);
    @(posedge clk);
    @(negedge clk);
    set_in(4, 1'b0, 0, 0);
    wait_done(4, 0, lat);
    chk("b2b first latency", lat, 4);
    chk("b2b first quotient", int'(q4), 4);
    chk("b2b first remainder", int'(r4), 1);
    set_in(4, 1'b1, 14, 3);
    @(posedge clk);
    @(negedge clk);
    set_in(4, 1'b0, 0, 0);
    chk("b2b second busy", int'(busy4), 1);
    chk("b2b second done low", int'(done4), 0);
    chk("b2b hold during run", int'(r4), 1);
    wait_done(4, 0, lat);
    chk("b2b second latency", lat, 4);
    chk("b2b second quotient", int'(q4), 4);
    chk("b2b second remainder", int'(r4), 2);
    @(posedge clk);
    @(negedge clk);

    // Start pulse in the middle of a run is ignored
    set_in(4, 1'b1, 13, 3);
    @(posedge clk);
    @(negedge clk);
    set_in(4, 1'b0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    set_in(4, 1'b1, 15, 1);
    @(posedge clk);
    @(negedge clk);
    set_in(4, 1'b0, 0, 0);
    chk("ignored start busy", int'(busy4), 1);
    chk("ignored start quotient held", int'(q4), 4);
    chk("ignored start remainder held", int'(r4), 2);
    wait_done(4, 2, lat);
    chk("ignored start latency", lat, 4);
    chk("ignored start quotient", int'(q4), 4);
    chk("ignored start remainder", int'(r4), 1);
    @(posedge clk);
    @(negedge clk);

    // Reset two cycles into 11/2
    set_in(4, 1'b1, 11, 2);
    @(posedge clk);
    @(negedge clk);
    set_in(4, 1'b0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset quotient", int'(q4), 0);
    chk("midreset remainder", int'(r4), 0);
    chk("midreset busy", int'(busy4), 0);
    chk("midreset done", int'(done4), 0);
    chk("midreset div_by_zero", int'(dz4), 0);
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (done4) seen++;
      end
      chk("midreset no done", seen, 0);
    end
    run_op("fresh 11/2", 4, 11, 2);

    // Exhaustive WIDTH=4 sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op($sformatf("w4 %0d/%0d", a, b), 4, a, b);

    // Randomized WIDTH=8
    run_op("w8 200/0", 8, 200, 0);
    run_op("w8 255/1", 8, 255, 1);
    for (int i = 0; i < 1000; i++) begin
      int a, b;
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      run_op($sformatf("w8 %0d/%0d", a, b), 8, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
